// File: rtl/packet_sender.sv
// packet_sender: serialises read-request (3-byte) and write (39-byte) packets from two DMA queues onto a UART byte stream.
module packet_sender (
  input  logic         clk,
  input  logic         resetn,
  input  logic         tx_busy,
  output logic [7:0]   tx_data,
  output logic         tx_en,
  input  logic [15:0]  dma_send_read_queue_data,
  input  logic         dma_send_read_queue_available,
  output logic         dma_send_read_queue_re,
  input  logic [15:0]  dma_send_write_queue_data,
  input  logic [287:0] dma_send_write_queue_data2,
  input  logic         dma_send_write_queue_available,
  output logic         dma_send_write_queue_re
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  state_t state, state_nx;
  logic [311:0] pkt;
  logic [5:0]   left;
  logic         first;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  // WAIT skips tx_busy on its first cycle because the UART raises busy one cycle late
  always_comb
    state_nx = state == IDLE ? ((dma_send_write_queue_available || dma_send_read_queue_available) ? SEND : IDLE) :
               state == SEND ? (tx_busy ? SEND : WAIT) :
               (first || tx_busy) ? WAIT : (left == 6'd0 ? IDLE : SEND);
  always_comb begin
    dma_send_write_queue_re = resetn && state == IDLE && dma_send_write_queue_available;
    dma_send_read_queue_re  = resetn && state == IDLE && dma_send_read_queue_available && !dma_send_write_queue_available;
    tx_en                   = state == SEND && !tx_busy;
    tx_data                 = pkt[311:304];
  end
  // Packet is held left-aligned and shifted out a byte per accepted tx_en, leaving zeros behind
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      pkt   <= '0;
      left  <= '0;
      first <= 1'b0;
    end else begin
      first <= tx_en;
      if (dma_send_write_queue_re) begin
        pkt  <= {8'h02, dma_send_write_queue_data, dma_send_write_queue_data2};
        left <= 6'd39;
      end else if (dma_send_read_queue_re) begin
        pkt  <= {8'h01, dma_send_read_queue_data, 288'd0};
        left <= 6'd3;
      end else if (tx_en) begin
        pkt  <= {pkt[303:0], 8'h00};
        left <= left - 6'd1;
      end
    end
endmodule

// File: tb/tb_packet_sender.sv
// tb_packet_sender: directed checks of packet_sender against a UART busy model and two queue models.
module tb_packet_sender;
  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         tx_busy;
  logic [7:0]   tx_data;
  logic         tx_en;
  logic [15:0]  rd_addr = '0;
  logic         read_re;
  logic [15:0]  wr_addr = '0;
  logic [287:0] wr_pl = '0;
  logic         write_re;
  logic         busy_force = 1'b0;
  int           busy_cnt = 0;
  int           rq = 0, wq = 0;
  int           rd_pops = 0, wr_pops = 0, bad_re = 0;
  int           checks = 0, errors = 0;
  logic [7:0]   rx[$];
  logic [7:0]   exp_q[$];

  always #5 clk = ~clk;
  assign tx_busy = busy_force || busy_cnt != 0;

  packet_sender dut (
    .clk(clk),
    .resetn(resetn),
    .tx_busy(tx_busy),
    .tx_data(tx_data),
    .tx_en(tx_en),
    .dma_send_read_queue_data(rd_addr),
    .dma_send_read_queue_available(rq != 0),
    .dma_send_read_queue_re(read_re),
    .dma_send_write_queue_data(wr_addr),
    .dma_send_write_queue_data2(wr_pl),
    .dma_send_write_queue_available(wq != 0),
    .dma_send_write_queue_re(write_re)
  );

  // UART busy for 10 cycles per accepted byte; queues scramble their head after a pop
  always @(posedge clk) begin
    if (tx_en && !tx_busy) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (write_re) begin
      wr_pops <= wr_pops + 1;
      if (wq == 0) bad_re <= bad_re + 1;
      wq <= wq - 1;
      wr_addr <= 16'hDEAD;
      wr_pl <= ~wr_pl;
    end
    if (read_re) begin
      rd_pops <= rd_pops + 1;
      if (rq == 0 || wq != 0) bad_re <= bad_re + 1;
      rq <= rq - 1;
      rd_addr <= 16'hBAD0;
    end
  end

  always @(negedge clk) if (tx_en) rx.push_back(tx_data);

  task automatic wait_bytes(input int n, input int budget);
    for (int i = 0; i < budget && rx.size() < n; i++) @(negedge clk);
    repeat (30) @(negedge clk);
  endtask

  task automatic clear_counts();
    @(negedge clk);
    rx.delete();
    exp_q.delete();
    rd_pops = 0;
    wr_pops = 0;
    bad_re = 0;
  endtask

  task automatic test_reset();
    #3 resetn = 1'b0;
    rq = 1;
    wq = 1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en got %b want 0", tx_en); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    if (write_re !== 1'b0) begin errors++; $display("FAIL reset_write_re got %b want 0", write_re); end
    if (read_re !== 1'b0) begin errors++; $display("FAIL reset_read_re got %b want 0", read_re); end
    rq = 0;
    wq = 0;
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (rx.size() != 0 || wr_pops + rd_pops != 0) begin
      errors++;
      $display("FAIL reset_quiet got bytes=%0d pops=%0d want 0 0", rx.size(), wr_pops + rd_pops);
    end
  endtask

  task automatic test_read();
    clear_counts();
    rd_addr = 16'h1234;
    rq = 1;
    exp_q = '{8'h01, 8'h12, 8'h34};
    wait_bytes(3, 300);
    checks += 3;
    if (rx.size() != 3) begin errors++; $display("FAIL read_count got %0d want 3", rx.size()); end
    if (rd_pops != 1) begin errors++; $display("FAIL read_pops got %0d want 1", rd_pops); end
    if (wr_pops != 0) begin errors++; $display("FAIL read_wpops got %0d want 0", wr_pops); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL read_byte%0d got %h want %h", i, rx[i], exp_q[i]); end
    end
  endtask

  task automatic test_write();
    clear_counts();
    wr_addr = 16'h00AB;
    wr_pl = '1;
    wq = 1;
    exp_q = '{8'h02, 8'h00, 8'hAB};
    for (int i = 0; i < 36; i++) exp_q.push_back(8'hFF);
    wait_bytes(39, 1500);
    checks += 2;
    if (rx.size() != 39) begin errors++; $display("FAIL write_count got %0d want 39", rx.size()); end
    if (wr_pops != 1) begin errors++; $display("FAIL write_pops got %0d want 1", wr_pops); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL write_byte%0d got %h want %h", i, rx[i], exp_q[i]); end
    end
  endtask

  task automatic test_priority();
    clear_counts();
    rd_addr = 16'h5678;
    wr_addr = 16'h0102;
    for (int i = 0; i < 36; i++) wr_pl[i*8 +: 8] = 8'(i);
    rq = 1;
    wq = 1;
    exp_q = '{8'h02, 8'h01, 8'h02};
    for (int k = 0; k < 36; k++) exp_q.push_back(8'(35 - k));
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h56);
    exp_q.push_back(8'h78);
    wait_bytes(42, 2000);
    checks += 4;
    if (rx.size() != 42) begin errors++; $display("FAIL prio_count got %0d want 42", rx.size()); end
    if (wr_pops != 1) begin errors++; $display("FAIL prio_wpops got %0d want 1", wr_pops); end
    if (rd_pops != 1) begin errors++; $display("FAIL prio_rpops got %0d want 1", rd_pops); end
    if (bad_re != 0) begin errors++; $display("FAIL prio_bad_re got %0d want 0", bad_re); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL prio_byte%0d got %h want %h", i, rx[i], exp_q[i]); end
    end
  endtask

  task automatic test_busy_hold();
    int bad = 0;
    clear_counts();
    busy_force = 1'b1;
    rd_addr = 16'hA5C3;
    rq = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      if (tx_en !== 1'b0 || tx_data !== 8'h01) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL busy_hold got %0d bad cycles want 0", bad); end
    busy_force = 1'b0;
    exp_q = '{8'h01, 8'hA5, 8'hC3};
    wait_bytes(3, 300);
    checks += 2;
    if (rx.size() != 3) begin errors++; $display("FAIL busy_count got %0d want 3", rx.size()); end
    if (rd_pops != 1) begin errors++; $display("FAIL busy_pops got %0d want 1", rd_pops); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL busy_byte%0d got %h want %h", i, rx[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    wr_addr = 16'h1357;
    wr_pl = '1;
    wq = 1;
    for (int i = 0; i < 600 && rx.size() < 5; i++) @(negedge clk);
    checks++;
    if (rx.size() != 5) begin errors++; $display("FAIL mid_reach got %0d bytes want 5", rx.size()); end
    rd_addr = 16'hBEEF;
    rq = 1;
    resetn = 1'b0;
    #1;
    checks += 4;
    if (tx_en !== 1'b0) begin errors++; $display("FAIL mid_tx_en got %b want 0", tx_en); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data got %h want 00", tx_data); end
    if (read_re !== 1'b0) begin errors++; $display("FAIL mid_read_re got %b want 0", read_re); end
    if (write_re !== 1'b0) begin errors++; $display("FAIL mid_write_re got %b want 0", write_re); end
    repeat (2) @(negedge clk);
    rx.delete();
    resetn = 1'b1;
    exp_q = '{8'h01, 8'hBE, 8'hEF};
    wait_bytes(3, 300);
    checks += 2;
    if (rx.size() != 3) begin errors++; $display("FAIL mid_count got %0d want 3", rx.size()); end
    if (wr_pops != 1) begin errors++; $display("FAIL mid_wpops got %0d want 1", wr_pops); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL mid_byte%0d got %h want %h", i, rx[i], exp_q[i]); end
    end
  endtask

  task automatic test_element0();
    clear_counts();
    wr_addr = 16'h0000;
    wr_pl = {18'h3FFFF, 270'd0};
    wq = 1;
    exp_q = '{8'h02, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hC0};
    for (int i = 0; i < 33; i++) exp_q.push_back(8'h00);
    wait_bytes(39, 1500);
    checks++;
    if (rx.size() != 39) begin errors++; $display("FAIL elem_count got %0d want 39", rx.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL elem_byte%0d got %h want %h", i, rx[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_priority();
    test_busy_hold();
    test_reset_mid();
    test_element0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
